// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: bus widths,
// stall bit indices, FSM state encoding and the contiguous stall masks.
package pipeline_ctrl_pkg;

  localparam int unsigned PC_WIDTH   = 32;
  localparam int unsigned PERF_WIDTH = 32;
  localparam int unsigned STALL_BUS  = 6;

  // Stall bit indices; the register between stages k and k+1 takes
  // stall[k] as current and stall[k+1] as next.
  localparam int unsigned StallPc  = 0;
  localparam int unsigned StallIf  = 1;
  localparam int unsigned StallId  = 2;
  localparam int unsigned StallEx  = 3;
  localparam int unsigned StallMem = 4;
  localparam int unsigned StallWb  = 5;

  typedef logic [STALL_BUS-1:0] stall_vec_t;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StMulti = 2'd1,
    StDone  = 2'd2,
    StFlush = 2'd3
  } ctrl_state_e;

  localparam stall_vec_t StallMaskNone  = 6'b000000;
  localparam stall_vec_t StallMaskIf    = 6'b000011;
  localparam stall_vec_t StallMaskId    = 6'b000111;
  localparam stall_vec_t StallMaskMulti = 6'b001111;
  localparam stall_vec_t StallMaskMem   = 6'b011111;

endpackage

// File: rtl/multi_cycle_counter.sv
// Loadable down-counter used to time multi-cycle EX operations.
// is_one flags the last stall cycle of the operation.
module multi_cycle_counter #(
  parameter int unsigned CNT_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 dec,
  input  logic [CNT_WIDTH-1:0] value,
  output logic                 is_one
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Load takes precedence over decrement; otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (dec) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_one = (cnt_q == CNT_WIDTH'(1));

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the five-stage pipeline.
// Optional performance counters are enabled with PIPELINE_CTRL_PERF_EN;
// without it stall_cycles and flush_count read 0 and no counter flops exist.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MULDIV_LATENCY = 32,
  parameter int unsigned CNT_WIDTH      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_req_if,
  input  logic                  stall_req_id,
  input  logic                  ex_multi_req,
  input  logic                  stall_req_mem,
  input  logic                  exception_req,
  input  logic [PC_WIDTH-1:0]   exception_pc,
  output logic [STALL_BUS-1:0]  stall,
  output logic                  flush,
  output logic [PC_WIDTH-1:0]   flush_pc,
  output logic                  ex_multi_done,
  output logic [PERF_WIDTH-1:0] stall_cycles,
  output logic [PERF_WIDTH-1:0] flush_count
);

  localparam logic [CNT_WIDTH-1:0] LoadValue = CNT_WIDTH'(MULDIV_LATENCY - 1);

  ctrl_state_e         state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                cnt_load, cnt_dec, cnt_is_one;

  multi_cycle_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .value (LoadValue),
    .is_one(cnt_is_one)
  );

  // State and latched flush PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state logic; an exception aborts any multi-cycle op in flight.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (exception_req) begin
          state_d = StFlush;
          pc_d    = exception_pc;
        end else if (ex_multi_req && !stall_req_mem) begin
          state_d  = StMulti;
          cnt_load = 1'b1;
        end
      end
      StMulti: begin
        cnt_dec = 1'b1;
        if (exception_req) begin
          state_d = StFlush;
          pc_d    = exception_pc;
        end else if (cnt_is_one) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (exception_req) begin
          state_d = StFlush;
          pc_d    = exception_pc;
        end else if (!stall_req_mem) begin
          state_d = StRun;
        end
      end
      StFlush: state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // Outputs: stall is zero-latency from requests; flush/done decode state.
  // An exception cycle stalls nothing since the flush follows next cycle.
  always_comb begin
    stall = StallMaskNone;
    if (!rst) begin
      unique case (state_q)
        StRun: begin
          if (exception_req)      stall = StallMaskNone;
          else if (stall_req_mem) stall = StallMaskMem;
          else if (ex_multi_req)  stall = StallMaskMulti;
          else if (stall_req_id)  stall = StallMaskId;
          else if (stall_req_if)  stall = StallMaskIf;
        end
        StMulti: begin
          if (exception_req)      stall = StallMaskNone;
          else if (stall_req_mem) stall = StallMaskMem;
          else                    stall = StallMaskMulti;
        end
        StDone: begin
          // ex_multi_req is ignored here so the finished op does not re-trigger.
          if (exception_req)      stall = StallMaskNone;
          else if (stall_req_mem) stall = StallMaskMem;
          else if (stall_req_id)  stall = StallMaskId;
          else if (stall_req_if)  stall = StallMaskIf;
        end
        StFlush: stall = StallMaskNone;
        default: stall = StallMaskNone;
      endcase
    end
  end

  assign flush         = (state_q == StFlush);
  assign flush_pc      = flush ? pc_q : '0;
  assign ex_multi_done = (state_q == StDone);

`ifdef PIPELINE_CTRL_PERF_EN
  logic [PERF_WIDTH-1:0] stall_cycles_q, flush_count_q;

  // Free-running wrap-around performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall[StallPc]) stall_cycles_q <= stall_cycles_q + 1'b1;
      if (flush)          flush_count_q  <= flush_count_q + 1'b1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
